// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and the decoder.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_ERR   = 3'd4
    } fetch_state_t;

    // addi x0, x0, 0 -- presented while no real instruction is held
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Control-flow opcodes, also decoded by the main decoder
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: sequential, PC-relative or register-indirect.
module next_pc_logic #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            branch_i,
    input  logic            jump_i,
    input  logic            jalr_i,
    input  logic            zero_i,
    input  logic [XLEN-1:0] imm_ext_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misaligned_o
);

    logic            taken;
    logic [XLEN-1:0] target;
    // Bit 0 of the JALR sum is always discarded by the architecture
    logic            unused_alu_lsb;

    assign unused_alu_lsb = alu_result_i[0];

    // Select target and flag targets that are not word aligned
    always_comb begin
        taken        = (branch_i & zero_i) | jump_i;
        target       = jalr_i ? {alu_result_i[XLEN-1:1], 1'b0} : (pc_i + imm_ext_i);
        next_pc_o    = taken ? target : (pc_i + XLEN'(4));
        misaligned_o = (next_pc_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, holds the
// instruction for the decoder and redirects the PC when it is consumed.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic            jump_i,
    input  logic            jalr_i,
    input  logic            zero_i,
    input  logic [XLEN-1:0] imm_ext_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [6:0]      opcode_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misaligned_o
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            req_q;
    logic            valid_q;
    logic            misaligned_q;

    logic [XLEN-1:0] next_pc_d;
    logic            next_misaligned_d;

    next_pc_logic #(
        .XLEN (XLEN)
    ) u_next_pc (
        .pc_i         (pc_q),
        .branch_i     (branch_i),
        .jump_i       (jump_i),
        .jalr_i       (jalr_i),
        .zero_i       (zero_i),
        .imm_ext_i    (imm_ext_i),
        .alu_result_i (alu_result_i),
        .next_pc_o    (next_pc_d),
        .misaligned_o (next_misaligned_d)
    );

    // Fetch FSM with registered request/valid outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                S_RESET: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    // rvalid without gnt is a stale response and is dropped
                    if (imem_gnt) begin
                        req_q <= 1'b0;
                        if (imem_rvalid) begin
                            instr_q <= imem_rdata;
                            valid_q <= 1'b1;
                            state_q <= S_HOLD;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        valid_q <= 1'b0;
                        if (next_misaligned_d) begin
                            misaligned_q <= 1'b1;
                            state_q      <= S_ERR;
                        end else begin
                            pc_q    <= next_pc_d;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_RESET;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[6:0];
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + XLEN'(4);
    assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        branch_i;
    logic        jump_i;
    logic        jalr_i;
    logic        zero_i;
    logic [31:0] imm_ext_i;
    logic [31:0] alu_result_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [6:0]  opcode_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        misaligned_o;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .jump_i        (jump_i),
        .jalr_i        (jalr_i),
        .zero_i        (zero_i),
        .imm_ext_i     (imm_ext_i),
        .alu_result_i  (alu_result_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .opcode_o      (opcode_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .misaligned_o  (misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge; outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        branch_i     = 1'b0;
        jump_i       = 1'b0;
        jalr_i       = 1'b0;
        zero_i       = 1'b0;
        imm_ext_i    = 32'h0;
        alu_result_i = 32'h0;
    endtask

    // wait (bounded) for a request, then answer it with gnt+rvalid together
    task automatic fetch(input logic [31:0] word);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_req_timeout: imem_req=%b required 1", imem_req);
        end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        $display("fetch: addr=%08h word=%08h valid=%b", pc_o, word, instr_valid_o);
    endtask

    // consume the held instruction with the given controls
    task automatic consume(input logic br, input logic jp, input logic jr,
                           input logic zr, input logic [31:0] imm, input logic [31:0] alu);
        branch_i     = br;
        jump_i       = jp;
        jalr_i       = jr;
        zero_i       = zr;
        imm_ext_i    = imm;
        alu_result_i = alu;
        stall_i      = 1'b0;
        tick();
        stall_i = 1'b1;
        clear_ctrl();
        $display("consume: br=%b jp=%b jr=%b zr=%b -> pc=%08h mis=%b", br, jp, jr, zr, pc_o, misaligned_o);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %08h want 00000000", pc_o); end
        checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %08h want 00000013", instr_o); end
        checks++; if (opcode_o !== 7'b0010011) begin errors++; $display("FAIL reset_opcode: got %b want 0010011", opcode_o); end
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", misaligned_o); end
        checks++; if (pc_plus4_o !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %08h want 00000004", pc_plus4_o); end
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b want 1", imem_req); end
        $display("test_reset: done");
    endtask

    task automatic test_same_cycle();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL sc_addr: got %08h want 00000000", imem_addr); end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL sc_valid: got %b want 1", instr_valid_o); end
        checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL sc_instr: got %08h want 00500093", instr_o); end
        checks++; if (opcode_o !== 7'b0010011) begin errors++; $display("FAIL sc_opcode: got %b want 0010011", opcode_o); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sc_req_hold: got %b want 0", imem_req); end
        consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (pc_o !== 32'h4) begin errors++; $display("FAIL sc_pc_next: got %08h want 00000004", pc_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL sc_valid_drop: got %b want 0", instr_valid_o); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL sc_req_next: got %b want 1", imem_req); end
        $display("test_same_cycle: done");
    endtask

    task automatic test_stall();
        // gnt alone, rvalid three cycles later
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req_wait: got %b want 0", imem_req); end
        tick();
        tick();
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL st_valid_wait: got %b want 0", instr_valid_o); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_006F;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (instr_o !== 32'h0000_006F) begin errors++; $display("FAIL st_instr: got %08h want 0000006f", instr_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr_o !== 32'h0000_006F) begin errors++; $display("FAIL st_instr_hold%0d: got %08h want 0000006f", i, instr_o); end
            checks++; if (pc_o !== 32'h4) begin errors++; $display("FAIL st_pc_hold%0d: got %08h want 00000004", i, pc_o); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req_hold%0d: got %b want 0", i, imem_req); end
            checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL st_valid_hold%0d: got %b want 1", i, instr_valid_o); end
        end
        // JAL from 0x4 by +0xC
        consume(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0);
        checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL st_jal_pc: got %08h want 00000010", pc_o); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL st_req_after: got %b want 1", imem_req); end
        $display("test_stall: done");
    endtask

    task automatic test_branch();
        fetch(32'h0000_0063);
        consume(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
        checks++; if (pc_o !== 32'h08) begin errors++; $display("FAIL br_taken: got %08h want 00000008", pc_o); end
        fetch(32'h0000_006F);
        consume(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0);
        checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL br_back: got %08h want 00000010", pc_o); end
        fetch(32'h0000_0063);
        consume(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        checks++; if (pc_o !== 32'h14) begin errors++; $display("FAIL br_not_taken: got %08h want 00000014", pc_o); end
        $display("test_branch: done");
    endtask

    task automatic test_wrap();
        fetch(32'h0000_006F);
        consume(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFE8, 32'h0);
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %08h want fffffffc", pc_o); end
        checks++; if (pc_plus4_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %08h want 00000000", pc_plus4_o); end
        fetch(32'h0000_0013);
        consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %08h want 00000000", pc_o); end
        $display("test_wrap: done");
    endtask

    task automatic test_jalr();
        fetch(32'h0000_0067);
        consume(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0101);
        checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL jalr_ok: got %08h want 00000100", pc_o); end
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL jalr_ok_mis: got %b want 0", misaligned_o); end
        fetch(32'h0000_0067);
        consume(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0103);
        checks++; if (misaligned_o !== 1'b1) begin errors++; $display("FAIL jalr_mis: got %b want 1", misaligned_o); end
        checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL jalr_mis_pc: got %08h want 00000100", pc_o); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL jalr_mis_req: got %b want 0", imem_req); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL jalr_mis_valid: got %b want 0", instr_valid_o); end
        // error state is terminal even with traffic and consume attempts
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        stall_i     = 1'b0;
        tick();
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        stall_i     = 1'b1;
        checks++; if (imem_req !== 1'b0 || instr_valid_o !== 1'b0 || misaligned_o !== 1'b1)
            begin errors++; $display("FAIL err_sticky: req=%b valid=%b mis=%b want 0 0 1", imem_req, instr_valid_o, misaligned_o); end
        $display("test_jalr: done");
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL rm_mis_clear: got %b want 0", misaligned_o); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_req1: got %b want 1", imem_req); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        // now waiting for data; reset wipes the outstanding request
        rst_n = 1'b0;
        tick();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", instr_valid_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rm_pc: got %08h want 00000000", pc_o); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_req2: got %b want 1", imem_req); end
        tick();
        imem_rvalid = 1'b0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rm_stale_valid: got %b want 0", instr_valid_o); end
        checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rm_stale_instr: got %08h want 00000013", instr_o); end
        fetch(32'h0010_0113);
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL rm_fresh_valid: got %b want 1", instr_valid_o); end
        checks++; if (instr_o !== 32'h0010_0113) begin errors++; $display("FAIL rm_fresh_instr: got %08h want 00100113", instr_o); end
        $display("test_reset_mid: done");
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall_i     = 1'b1;
        clear_ctrl();
        test_reset();
        test_same_cycle();
        test_stall();
        test_branch();
        test_wrap();
        test_jalr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
